// File: rtl/rst_sync.sv
// Reset conditioner: assertion on the first edge that samples rst_n_i low, release after STAGES consecutive high samples.
// Output comes straight from the last chain flop, so it only ever changes on a clk_i rising edge.
`timescale 1ns/1ps

module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_o
);

    // Power-up value of zero holds the design in reset before the first edge; kept as a true synchronizer chain.
    (* preserve, altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED; -name DONT_RETIME ON; -name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
    logic [STAGES-1:0] sync_q = '0;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_o = sync_q[STAGES-1];

endmodule

// File: tb/tb_rst_sync.sv
// Bench for rst_sync: STAGES=2 and STAGES=4 instances share one reset request and are checked
// against a consecutive-high-sample count model.
`timescale 1ns/1ps

module tb_rst_sync;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    logic rst_n_o2;
    logic rst_n_o4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic in_v;
        logic exp2;
        logic exp4;
    } vec_t;

    vec_t vecs[12];

    always #2.5 clk_i = ~clk_i;

    rst_sync #(.STAGES(2)) u_dut2 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rst_n_o (rst_n_o2)
    );

    rst_sync #(.STAGES(4)) u_dut4 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rst_n_o (rst_n_o4)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin
        int cnt;
        logic v;

        vecs[0]  = '{1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1};

        // Power-up and first release
        #1;
        check("powerup_o2", rst_n_o2, 1'b0);
        check("powerup_o4", rst_n_o4, 1'b0);
        #1   rst_n_i = 1'b1;                          // t=2
        #1.5 check("release_edge1_o2", rst_n_o2, 1'b0);   // t=3.5
        #5   check("release_edge2_o2", rst_n_o2, 1'b1);   // t=8.5
        check("release_edge2_o4", rst_n_o4, 1'b0);
        #4.5 rst_n_i = 1'b0;                          // t=13
        #3   check("assert_before_edge_o2", rst_n_o2, 1'b1); // t=16
        #2.5 check("assert_edge_o2", rst_n_o2, 1'b0);     // t=18.5
        #7.5 rst_n_i = 1'b1;                          // t=26
        #2.5 check("rerelease_edge1_o2", rst_n_o2, 1'b0); // t=28.5
        #5   check("rerelease_edge2_o2", rst_n_o2, 1'b1); // t=33.5
        check("rerelease_edge2_o4", rst_n_o4, 1'b0);
        #5   check("rerelease_edge3_o4", rst_n_o4, 1'b0); // t=38.5
        #5   check("rerelease_edge4_o4", rst_n_o4, 1'b1); // t=43.5
        check("rerelease_edge4_o2", rst_n_o2, 1'b1);

        // Per-cycle vectors: assertion, abort during release for both depths
        for (int i = 0; i < 12; i++) begin
            rst_n_i = vecs[i].in_v;
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_o2", i), rst_n_o2, vecs[i].exp2);
            check($sformatf("vec%0d_o4", i), rst_n_o4, vecs[i].exp4);
        end

        // Sub-cycle low pulse between edges must be ignored
        rst_n_i = 1'b0;
        #0.5 check("glitch_during_o2", rst_n_o2, 1'b1);
        check("glitch_during_o4", rst_n_o4, 1'b1);
        #0.5 rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("glitch_after_o2", rst_n_o2, 1'b1);
        check("glitch_after_o4", rst_n_o4, 1'b1);

        // Randomized requests against a consecutive-high-sample count
        cnt = 8;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v && ($urandom_range(0, 4) == 0)) begin
                rst_n_i = 1'b0;
                #1 rst_n_i = 1'b1;
            end else begin
                rst_n_i = v;
            end
            @(posedge clk_i);
            cnt = v ? ((cnt < 8) ? cnt + 1 : 8) : 0;
            #1;
            check($sformatf("rand%0d_o2", i), rst_n_o2, (cnt >= 2));
            check($sformatf("rand%0d_o4", i), rst_n_o4, (cnt >= 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
